ibex_bloom_unit: RTL



---
 rtl/ibex_pkg.sv | 21 ++
 rtl/ibex_bloom_hash.sv | 31 +++
 rtl/ibex_bloom_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the bloom-filter coprocessor: operation encoding,
// FSM states and the hash rotate amount.
package ibex_pkg;

  typedef enum logic [4:0] {
    BLOOM_INSERT = 5'd0,
    BLOOM_CHECK  = 5'd1,
    BLOOM_CLEAR  = 5'd2,
    BLOOM_COUNT  = 5'd3
  } bloom_op_e;

  typedef enum logic [1:0] {
    BLOOM_IDLE,
    BLOOM_HASH,
    BLOOM_CLR,
    BLOOM_DONE
  } bloom_state_e;

  localparam int unsigned BLOOM_ROT = 13;

endpackage

// File: rtl/ibex_bloom_hash.sv
// Combinational double-hash generator: h1 = fold(k), h2 = fold(rotl(k,13)) | 1.
// h2 is forced odd so the probe sequence walks distinct indices.
module ibex_bloom_hash
  import ibex_pkg::*;
#(
  parameter int unsigned IdxW = 8
) (
  input  logic [31:0]     k,
  output logic [IdxW-1:0] h1,
  output logic [IdxW-1:0] h2
);

  localparam int unsigned NumSlices = (32 + IdxW - 1) / IdxW;

  // The top slice is zero-extended naturally by the right shift.
  function automatic logic [IdxW-1:0] fold(input logic [31:0] x);
    logic [IdxW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NumSlices; i++) begin
      acc = acc ^ IdxW'(x >> (i * IdxW));
    end
    return acc;
  endfunction

  logic [31:0] k_rot;

  assign k_rot = (k << BLOOM_ROT) | (k >> (32 - BLOOM_ROT));
  assign h1    = fold(k);
  assign h2    = fold(k_rot) | IdxW'(1);

endmodule

// File: rtl/ibex_bloom_unit.sv
// Multi-cycle bloom-filter coprocessor for the EX stage: INSERT / CHECK /
// CLEAR / COUNT against a local bit array with a saturating insert counter.
//
// state | meaning
// IDLE  | waiting for en_i; latches op and operands, forms hashes
// HASH  | one probe per cycle (INSERT sets, CHECK tests)
// CLR   | zeroes one 32-bit array word per cycle
// DONE  | valid_o pulse with registered result
module ibex_bloom_unit
  import ibex_pkg::*;
#(
  parameter int unsigned IdxW    = 8,
  parameter int unsigned NumHash = 3,
  parameter int unsigned CntW    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] key_i,
  input  logic [31:0] salt_i,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        busy_o
);

  localparam int unsigned ArrBits  = 1 << IdxW;
  localparam int unsigned NumWords = (IdxW > 5) ? (1 << (IdxW - 5)) : 1;
  localparam int unsigned PtrW     = (IdxW > 5) ? (IdxW - 5) : 1;

  bloom_state_e    state_q, state_d;
  bloom_op_e       op_q;
  logic [IdxW-1:0] idx_q, h2_q;
  logic [IdxW-1:0] h1, h2;
  logic [2:0]      j_q;
  logic [PtrW-1:0] wptr_q;
  logic [IdxW-1:0] wbase;
  logic [ArrBits-1:0] bit_array_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     result_q, result_d;

  logic accept, step, set_bit, clr_word, cnt_inc, cnt_clr;
  logic last_probe, last_word;

  ibex_bloom_hash #(.IdxW(IdxW)) u_hash (
    .k  (key_i ^ salt_i),
    .h1 (h1),
    .h2 (h2)
  );

  assign last_probe = (j_q == 3'(NumHash - 1));
  assign last_word  = (wptr_q == PtrW'(NumWords - 1));
  assign wbase      = IdxW'({wptr_q, 5'b0});

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    accept   = 1'b0;
    step     = 1'b0;
    set_bit  = 1'b0;
    clr_word = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      BLOOM_IDLE: begin
        if (en_i) begin
          accept   = 1'b1;
          result_d = (op_i == BLOOM_COUNT) ? 32'(cnt_q) : 32'd0;
          case (op_i)
            BLOOM_INSERT, BLOOM_CHECK: state_d = BLOOM_HASH;
            BLOOM_CLEAR:               state_d = BLOOM_CLR;
            default:                   state_d = BLOOM_DONE;
          endcase
        end
      end
      BLOOM_HASH: begin
        if (op_q == BLOOM_INSERT) begin
          set_bit = 1'b1;
          step    = 1'b1;
          if (last_probe) begin
            cnt_inc  = 1'b1;
            result_d = 32'd0;
            state_d  = BLOOM_DONE;
          end
        end else if (!bit_array_q[idx_q]) begin
          // CHECK exits on the first clear bit.
          result_d = 32'd0;
          state_d  = BLOOM_DONE;
        end else if (last_probe) begin
          result_d = 32'd1;
          state_d  = BLOOM_DONE;
        end else begin
          step = 1'b1;
        end
      end
      BLOOM_CLR: begin
        clr_word = 1'b1;
        if (last_word) begin
          cnt_clr  = 1'b1;
          result_d = 32'd0;
          state_d  = BLOOM_DONE;
        end
      end
      BLOOM_DONE: state_d = BLOOM_IDLE;
      default:    state_d = BLOOM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BLOOM_IDLE;
      op_q        <= BLOOM_INSERT;
      idx_q       <= '0;
      h2_q        <= '0;
      j_q         <= '0;
      wptr_q      <= '0;
      bit_array_q <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q   <= bloom_op_e'(op_i);
        idx_q  <= h1;
        h2_q   <= h2;
        j_q    <= '0;
        wptr_q <= '0;
      end
      if (step) begin
        idx_q <= idx_q + h2_q;
        j_q   <= j_q + 3'd1;
      end
      if (set_bit) bit_array_q[idx_q] <= 1'b1;
      if (clr_word) begin
        bit_array_q[wbase +: 32] <= '0;
        wptr_q                   <= wptr_q + PtrW'(1);
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign valid_o  = (state_q == BLOOM_DONE);
  assign busy_o   = (state_q != BLOOM_IDLE);
  assign result_o = result_q;

endmodule
